// File: rtl/regfile_bank_pkg.sv
// Shared sizing constants and types for the architectural register bank.
package regfile_bank_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef reg_data_t [REG_COUNT-1:0] reg_vec_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : regfile_bank_pkg

// File: rtl/mux_32.sv
// 32-way selector of 32-bit words, used by each register read port.
module mux_32
  import regfile_bank_pkg::*;
(
  input  reg_vec_t  data_i,
  input  reg_addr_t sel_i,
  output reg_data_t data_o
);

  always_comb begin
    data_o = data_i[sel_i];
  end

endmodule : mux_32

// File: rtl/regfile_read_port.sv
// One register read port: mux_32 over the bank plus the optional staging bypass.
// Bypass compare is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_bank_pkg::*;
(
  input  reg_vec_t  regs_i,
  input  reg_addr_t addr_i,
  input  logic      stg_valid_i,
  input  reg_addr_t stg_addr_i,
  input  reg_data_t stg_data_i,
  output reg_data_t data_o
);

  reg_data_t mux_data;

  mux_32 u_mux (
    .data_i (regs_i),
    .sel_i  (addr_i),
    .data_o (mux_data)
  );

`ifdef REGFILE_BYPASS_EN
  // stg_valid implies a nonzero address, so register 0 can never be bypassed.
  always_comb begin
    data_o = mux_data;
    if (stg_valid_i && (stg_addr_i == addr_i)) begin
      data_o = stg_data_i;
    end
  end
`else
  logic unused_stg;

  always_comb begin
    unused_stg = stg_valid_i ^ (^stg_addr_i) ^ (^stg_data_i);
    data_o     = mux_data;
  end
`endif

endmodule : regfile_read_port

// File: rtl/regfile_bank.sv
// 32x32 architectural register bank: one staged write port, two read ports.
// Optional staging bypass on reads is enabled by defining REGFILE_BYPASS_EN.
module regfile_bank
  import regfile_bank_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_writeEnable,
  input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
  input  logic [REG_DATA_W-1:0] data_writeReg,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
  output logic [REG_DATA_W-1:0] data_readRegA,
  output logic [REG_DATA_W-1:0] data_readRegB
);

  // Register 0 has no storage; it is a constant zero in the read vector.
  reg_data_t [REG_COUNT-1:1] regs_q;
  reg_vec_t                  rd_vec;

  logic      stg_valid_q, stg_valid_d;
  reg_addr_t stg_addr_q,  stg_addr_d;
  reg_data_t stg_data_q,  stg_data_d;

  always_comb begin
    stg_valid_d = ctrl_writeEnable && (ctrl_writeReg != REG_ZERO);
    stg_addr_d  = ctrl_writeReg;
    stg_data_d  = data_writeReg;
    rd_vec      = {regs_q, {REG_DATA_W{1'b0}}};
  end

  // Capture and commit share an edge, so back-to-back writes never stall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q      <= '0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (stg_valid_q && (stg_addr_q == reg_addr_t'(i))) begin
          regs_q[i] <= stg_data_q;
        end
      end
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  regfile_read_port u_port_a (
    .regs_i      (rd_vec),
    .addr_i      (ctrl_readRegA),
    .stg_valid_i (stg_valid_q),
    .stg_addr_i  (stg_addr_q),
    .stg_data_i  (stg_data_q),
    .data_o      (data_readRegA)
  );

  regfile_read_port u_port_b (
    .regs_i      (rd_vec),
    .addr_i      (ctrl_readRegB),
    .stg_valid_i (stg_valid_q),
    .stg_addr_i  (stg_addr_q),
    .stg_data_i  (stg_data_q),
    .data_o      (data_readRegB)
  );

endmodule : regfile_bank
